// File: rtl/dcache_pkg.sv
// Shared types and defaults for the direct-mapped write-back data cache.
// Holds the controller state encoding and the byte-lane extraction helper.
package dcache_pkg;

    localparam int DEF_INDEX_W  = 3;
    localparam int DEF_OFFSET_W = 2;
    localparam int DEF_TAG_W    = 8 - DEF_INDEX_W - DEF_OFFSET_W;
    localparam int BLOCK_W      = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    // Byte 0 of a block lives in bits [7:0].
    function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk, input logic [1:0] off);
        return blk[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dcache_store.sv
// Valid/dirty/tag/data arrays of the cache with one block-write port (line fill)
// and one byte-write port (store hit). Only valid and dirty are reset.
module dcache_store import dcache_pkg::*; #(
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int TAG_W    = DEF_TAG_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  rd_index,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [BLOCK_W-1:0]  rd_block,
    input  logic                blk_we,
    input  logic [INDEX_W-1:0]  blk_index,
    input  logic [TAG_W-1:0]    blk_tag,
    input  logic [BLOCK_W-1:0]  blk_data,
    input  logic                byte_we,
    input  logic [INDEX_W-1:0]  byte_index,
    input  logic [OFFSET_W-1:0] byte_offset,
    input  logic [7:0]          byte_data
);

    localparam int SETS = 2 ** INDEX_W;

    logic [SETS-1:0]    valid_r;
    logic [SETS-1:0]    dirty_r;
    logic [TAG_W-1:0]   tag_r  [SETS];
    logic [BLOCK_W-1:0] data_r [SETS];

    // Line status: a fill leaves the line valid and clean, a store hit dirties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            dirty_r <= '0;
        end else if (blk_we) begin
            valid_r[blk_index] <= 1'b1;
            dirty_r[blk_index] <= 1'b0;
        end else if (byte_we) begin
            dirty_r[byte_index] <= 1'b1;
        end else begin
            valid_r <= valid_r;
            dirty_r <= dirty_r;
        end
    end

    // Tag and data arrays are not reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (blk_we) begin
            tag_r[blk_index]  <= blk_tag;
            data_r[blk_index] <= blk_data;
        end else if (byte_we) begin
            data_r[byte_index][{byte_offset, 3'b000} +: 8] <= byte_data;
        end else begin
            data_r[byte_index] <= data_r[byte_index];
        end
    end

    assign rd_valid = valid_r[rd_index];
    assign rd_dirty = dirty_r[rd_index];
    assign rd_tag   = tag_r[rd_index];
    assign rd_block = data_r[rd_index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller: hit detection,
// miss FSM (write-back then fetch then fill) and memory-port muxing.
module dcache_controller import dcache_pkg::*; #(
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int TAG_W    = 8 - INDEX_W - OFFSET_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     READ,
    input  logic                     WRITE,
    input  logic [7:0]               ADDRESS,
    input  logic [7:0]               WRITEDATA,
    output logic [7:0]               READDATA,
    output logic                     BUSYWAIT,
    output logic                     MEM_READ,
    output logic                     MEM_WRITE,
    output logic [TAG_W+INDEX_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0]       MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]       MEM_READDATA,
    input  logic                     MEM_BUSYWAIT
);

    state_t state_r, next_s;

    logic [TAG_W-1:0]    addr_tag_s;
    logic [INDEX_W-1:0]  index_s;
    logic [OFFSET_W-1:0] offset_s;
    logic                line_valid_s, line_dirty_s, hit_s, req_s;
    logic [TAG_W-1:0]    line_tag_s;
    logic [BLOCK_W-1:0]  line_block_s;
    logic [BLOCK_W-1:0]  fill_r;
    logic                blk_we_s, byte_we_s;

    assign addr_tag_s = ADDRESS[7 -: TAG_W];
    assign index_s    = ADDRESS[OFFSET_W +: INDEX_W];
    assign offset_s   = ADDRESS[OFFSET_W-1:0];
    assign req_s      = READ || WRITE;
    assign hit_s      = line_valid_s && (line_tag_s == addr_tag_s);

    dcache_store #(
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .TAG_W    (TAG_W)
    ) u_store (
        .clk         (CLK),
        .rst         (RESET),
        .rd_index    (index_s),
        .rd_valid    (line_valid_s),
        .rd_dirty    (line_dirty_s),
        .rd_tag      (line_tag_s),
        .rd_block    (line_block_s),
        .blk_we      (blk_we_s),
        .blk_index   (index_s),
        .blk_tag     (addr_tag_s),
        .blk_data    (fill_r),
        .byte_we     (byte_we_s),
        .byte_index  (index_s),
        .byte_offset (offset_s),
        .byte_data   (WRITEDATA)
    );

    // Controller state register; reset aborts any memory transaction at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Fetched block is captured at the completing edge and written in UPDATE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fill_r <= '0;
        end else if ((state_r == FETCH) && !MEM_BUSYWAIT) begin
            fill_r <= MEM_READDATA;
        end else begin
            fill_r <= fill_r;
        end
    end

    // Next state, memory port drive and array write enables.
    always_comb begin
        next_s        = state_r;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        blk_we_s      = 1'b0;
        byte_we_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s && !hit_s) begin
                    next_s = (line_valid_s && line_dirty_s) ? WRITEBACK : FETCH;
                end else if (WRITE && hit_s) begin
                    byte_we_s = 1'b1;
                end else begin
                    next_s = IDLE;
                end
            end
            WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {line_tag_s, index_s};
                MEM_WRITEDATA = line_block_s;
                if (!MEM_BUSYWAIT) begin
                    next_s = FETCH;
                end else begin
                    next_s = WRITEBACK;
                end
            end
            FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {addr_tag_s, index_s};
                if (!MEM_BUSYWAIT) begin
                    next_s = UPDATE;
                end else begin
                    next_s = FETCH;
                end
            end
            UPDATE: begin
                blk_we_s = 1'b1;
                next_s   = IDLE;
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // CPU-side outputs are combinational so a read hit has zero latency.
    always_comb begin
        BUSYWAIT = !RESET && ((state_r != IDLE) || (req_s && !hit_s));
        if ((state_r == IDLE) && READ && !WRITE && hit_s) begin
            READDATA = get_byte(line_block_s, offset_s);
        end else begin
            READDATA = 8'h00;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios followed by
// random byte traffic, compared against a set-array reference model and a memory model.
module tb_dcache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req, wr_req;
    logic [7:0]  addr, wdata, rdata;
    logic        busy, mem_rd, mem_wr;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    // external memory seen by the DUT, and the model's own copy of it
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    // reference cache contents
    bit          mvalid [8];
    bit          mdirty [8];
    logic [2:0]  mtag   [8];
    logic [31:0] mdata  [8];

    int          mem_lat = 0;
    int          wb_count = 0, fetch_count = 0, both_cnt = 0;
    logic [5:0]  last_wb_addr = 6'h0, last_fetch_addr = 6'h0;
    logic [31:0] last_wb_data = 32'h0;

    dcache_controller dut (
        .CLK           (clk),
        .RESET         (rst),
        .READ          (rd_req),
        .WRITE         (wr_req),
        .ADDRESS       (addr),
        .WRITEDATA     (wdata),
        .READDATA      (rdata),
        .BUSYWAIT      (busy),
        .MEM_READ      (mem_rd),
        .MEM_WRITE     (mem_wr),
        .MEM_ADDRESS   (mem_addr),
        .MEM_WRITEDATA (mem_wdata),
        .MEM_READDATA  (mem_rdata),
        .MEM_BUSYWAIT  (mem_busy)
    );

    always #5 clk = ~clk;

    // memory completes a transaction on an edge with request high and not busy
    always @(posedge clk) begin
        if (!rst && (mem_rd || mem_wr) && !mem_busy) begin
            if (mem_wr) begin
                mem[mem_addr] = mem_wdata;
                last_wb_addr  = mem_addr;
                last_wb_data  = mem_wdata;
                wb_count++;
            end else begin
                last_fetch_addr = mem_addr;
                fetch_count++;
            end
        end
    end

    // memory busy generator: mem_lat busy cycles for every new request
    logic [6:0] cur_kind = 7'h0;
    bit         active = 1'b0;
    int         busy_left = 0;
    always @(negedge clk) begin
        if (mem_rd && mem_wr) both_cnt++;
        if (rst || !(mem_rd || mem_wr)) begin
            active   = 1'b0;
            mem_busy = 1'b0;
        end else begin
            if (!active || cur_kind != {mem_wr, mem_addr}) begin
                active    = 1'b1;
                cur_kind  = {mem_wr, mem_addr};
                busy_left = mem_lat;
            end
            if (busy_left > 0) begin
                mem_busy = 1'b1;
                busy_left--;
            end else begin
                mem_busy = 1'b0;
            end
            mem_rdata = mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
    endtask

    // One CPU request, held until the cache stops stalling, checked against the model.
    task automatic cpu_op(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd);
        logic [2:0]  idx    = a[4:2];
        logic [1:0]  off    = a[1:0];
        logic [2:0]  tg     = a[7:5];
        bit          hit_e  = mvalid[idx] && (mtag[idx] == tg);
        bit          wb_e   = !hit_e && mvalid[idx] && mdirty[idx];
        logic [31:0] victim = mdata[idx];
        logic [5:0]  vaddr  = {mtag[idx], idx};
        int          wb0    = wb_count;
        int          f0     = fetch_count;
        int          n      = 0;
        logic [31:0] blk;
        @(posedge clk);
        #1;
        rd_req = rd; wr_req = wr; addr = a; wdata = wd;
        @(negedge clk);
        check("busy_first", 32'(busy), 32'(!hit_e));
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_release", 32'(busy), 32'd0);
        if (!hit_e) begin
            if (wb_e) ref_mem[vaddr] = victim;
            mvalid[idx] = 1'b1;
            mdirty[idx] = 1'b0;
            mtag[idx]   = tg;
            mdata[idx]  = ref_mem[{tg, idx}];
        end
        blk = mdata[idx];
        if (rd && !wr) check("readdata", 32'(rdata), 32'(blk[{off, 3'b000} +: 8]));
        @(posedge clk);
        #1;
        rd_req = 1'b0; wr_req = 1'b0;
        check("writeback_count", 32'(wb_count - wb0), 32'(wb_e));
        check("fetch_count", 32'(fetch_count - f0), 32'(!hit_e));
        if (wb_e) begin
            check("wb_addr", 32'(last_wb_addr), 32'(vaddr));
            check("wb_data", last_wb_data, victim);
        end
        if (!hit_e) check("fetch_addr", 32'(last_fetch_addr), 32'({tg, idx}));
        if (wr) begin
            mdata[idx][{off, 3'b000} +: 8] = wd;
            mdirty[idx] = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[1] = 32'h44332211;
        ref_mem[1] = 32'h44332211;
        model_reset();

        // reset with a request already raised: everything must stay quiet
        rst = 1'b1; rd_req = 1'b1; wr_req = 1'b0; addr = 8'h05; wdata = 8'h00;
        #1;
        check("rst_busywait", 32'(busy), 32'd0);
        check("rst_mem_read", 32'(mem_rd), 32'd0);
        check("rst_mem_write", 32'(mem_wr), 32'd0);
        check("rst_mem_address", 32'(mem_addr), 32'd0);
        check("rst_mem_writedata", mem_wdata, 32'd0);
        check("rst_readdata", 32'(rdata), 32'd0);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // cold read miss with 3 busy cycles; write hit; zero-latency read back
        mem_lat = 3;
        cpu_op(1'b1, 1'b0, 8'h05, 8'h00);
        check("cold_fetch_addr", 32'(last_fetch_addr), 32'h01);
        cpu_op(1'b0, 1'b1, 8'h06, 8'hAB);
        cpu_op(1'b1, 1'b0, 8'h06, 8'h00);
        // dirty eviction of set 1, then evict the new dirty line to see its byte
        mem_lat = 2;
        cpu_op(1'b0, 1'b1, 8'h25, 8'h7F);
        check("dirty_wb_addr", 32'(last_wb_addr), 32'h01);
        check("dirty_fetch_addr", 32'(last_fetch_addr), 32'h09);
        cpu_op(1'b1, 1'b0, 8'h05, 8'h00);
        // clean eviction, then simultaneous read+write on a hit
        mem_lat = 0;
        cpu_op(1'b1, 1'b0, 8'h45, 8'h00);
        cpu_op(1'b1, 1'b1, 8'h45, 8'h5A);
        cpu_op(1'b1, 1'b0, 8'h45, 8'h00);
        // address 0xFF: set 7, offset 3
        cpu_op(1'b1, 1'b0, 8'hFF, 8'h00);

        // reset asserted mid-fetch
        mem_lat = 5;
        @(posedge clk);
        #1;
        rd_req = 1'b1; addr = 8'h88;
        n = 0;
        while (!mem_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midfetch_seen", 32'(mem_rd), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midfetch_mem_read", 32'(mem_rd), 32'd0);
        check("midfetch_mem_write", 32'(mem_wr), 32'd0);
        check("midfetch_busywait", 32'(busy), 32'd0);
        check("midfetch_mem_address", 32'(mem_addr), 32'd0);
        #1;
        rst = 1'b0;
        rd_req = 1'b0;
        model_reset();
        mem_lat = 1;
        cpu_op(1'b1, 1'b0, 8'h88, 8'h00);

        // random traffic over a few tags so hits, clean and dirty misses all occur
        for (int k = 0; k < 300; k++) begin
            bit rd = 1'($urandom_range(0, 1));
            bit wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            mem_lat = $urandom_range(0, 3);
            cpu_op(rd, wr, {3'($urandom_range(0, 3)), 5'($urandom)}, 8'($urandom));
        end

        check("never_both_requests", 32'(both_cnt), 32'd0);
        for (int i = 0; i < 64; i++) check("memory_image", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
